// File: rtl/am2940_dma_channel.sv
// Am2940-style DMA address-generator channel: CR, AR/AC, WR/WC, DONE, read-back.
// Optional feature macro DMA_DONE_IRQ_EN adds a sticky done interrupt (irq/irq_clr).
module am2940_dma_channel #(
    parameter int         W        = 8,
    parameter logic [2:0] CR_RESET = 3'b000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   instr,
    input  logic         instr_valid,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         data_oe,
`ifdef DMA_DONE_IRQ_EN
    input  logic         irq_clr,
    output logic         irq,
`endif
    input  logic         cnt_en,
    output logic [W-1:0] addr_out,
    output logic [W-1:0] wc_out,
    output logic [2:0]   cr_out,
    output logic         run,
    output logic         done
);

    typedef enum logic [2:0] {
        WRCR = 3'b000,
        RDCR = 3'b001,
        RDWC = 3'b010,
        RDAC = 3'b011,
        REIN = 3'b100,
        LDAD = 3'b101,
        LDWC = 3'b110,
        ENCT = 3'b111
    } instr_e;

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = '0;

    logic [2:0]   cr_q, cr_d;
    logic [W-1:0] ar_q, ar_d;
    logic [W-1:0] ac_q, ac_d;
    logic [W-1:0] wr_q, wr_d;
    logic [W-1:0] wc_q, wc_d;
    logic         run_q, run_d;
    logic [W-1:0] dout_q, dout_d;
    logic         doe_q, doe_d;
    logic [1:0]   mode;
    logic         done_c;
    logic         step;
    instr_e       op;

    assign op   = instr_e'(instr);
    assign mode = cr_q[1:0];
    // Modes 1 and 3 count WC upward from zero, so loads clear it.
    assign step = run_q & cnt_en & ~done_c & ~instr_valid;

    // Per-mode terminal condition from registered state.
    always_comb begin
        done_c = 1'b0;
        case (mode)
            2'd0:    done_c = (wc_q == ZERO);
            2'd1:    done_c = (wc_q == wr_q);
            2'd2:    done_c = (ac_q == wr_q);
            default: done_c = 1'b0;
        endcase
    end

    // Next-state: an instruction always wins over a transfer step.
    always_comb begin
        cr_d   = cr_q;
        ar_d   = ar_q;
        ac_d   = ac_q;
        wr_d   = wr_q;
        wc_d   = wc_q;
        run_d  = run_q;
        dout_d = dout_q;
        doe_d  = 1'b0;
        if (instr_valid) begin
            unique case (op)
                WRCR: begin
                    cr_d  = data_in[2:0];
                    run_d = 1'b0;
                end
                RDCR: begin
                    dout_d = W'(cr_q);
                    doe_d  = 1'b1;
                end
                RDWC: begin
                    dout_d = wc_q;
                    doe_d  = 1'b1;
                end
                RDAC: begin
                    dout_d = ac_q;
                    doe_d  = 1'b1;
                end
                REIN: begin
                    ac_d  = ar_q;
                    wc_d  = mode[0] ? ZERO : wr_q;
                    run_d = 1'b0;
                end
                LDAD: begin
                    ar_d  = data_in;
                    ac_d  = data_in;
                    run_d = 1'b0;
                end
                LDWC: begin
                    wr_d  = data_in;
                    wc_d  = mode[0] ? ZERO : data_in;
                    run_d = 1'b0;
                end
                ENCT: begin
                    run_d = 1'b1;
                end
            endcase
        end else if (step) begin
            ac_d = cr_q[2] ? (ac_q - ONE) : (ac_q + ONE);
            case (mode)
                2'd0:    wc_d = wc_q - ONE;
                2'd2:    wc_d = wc_q;
                default: wc_d = wc_q + ONE;
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cr_q   <= CR_RESET;
            ar_q   <= '0;
            ac_q   <= '0;
            wr_q   <= '0;
            wc_q   <= '0;
            run_q  <= 1'b0;
            dout_q <= '0;
            doe_q  <= 1'b0;
        end else begin
            cr_q   <= cr_d;
            ar_q   <= ar_d;
            ac_q   <= ac_d;
            wr_q   <= wr_d;
            wc_q   <= wc_d;
            run_q  <= run_d;
            dout_q <= dout_d;
            doe_q  <= doe_d;
        end
    end

`ifdef DMA_DONE_IRQ_EN
    logic irq_q, irq_d;
    logic done_q;

    // Sticky interrupt on done rising; a set beats a same-cycle clear.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr || (instr_valid && op == WRCR)) begin
            irq_d = 1'b0;
        end
        if (done_c && !done_q) begin
            irq_d = 1'b1;
        end
    end

    // Edge-detect history resets high so reset itself raises no irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q  <= 1'b0;
            done_q <= 1'b1;
        end else begin
            irq_q  <= irq_d;
            done_q <= done_c;
        end
    end

    assign irq = irq_q;
`endif

    assign data_out = dout_q;
    assign data_oe  = doe_q;
    assign addr_out = ac_q;
    assign wc_out   = wc_q;
    assign cr_out   = cr_q;
    assign run      = run_q;
    assign done     = done_c;

endmodule

// File: tb/tb_am2940_dma_channel.sv
// Bench for am2940_dma_channel: vector table plus read-back scoreboard.
// Irq sequence is compiled only with DMA_DONE_IRQ_EN.
module tb_am2940_dma_channel;

    localparam logic [2:0] WRCR = 3'b000;
    localparam logic [2:0] RDCR = 3'b001;
    localparam logic [2:0] RDWC = 3'b010;
    localparam logic [2:0] RDAC = 3'b011;
    localparam logic [2:0] REIN = 3'b100;
    localparam logic [2:0] LDAD = 3'b101;
    localparam logic [2:0] LDWC = 3'b110;
    localparam logic [2:0] ENCT = 3'b111;

    typedef struct {
        logic       r;
        logic       iv;
        logic [2:0] op;
        logic [7:0] din;
        logic       ce;
        logic [7:0] ea;
        logic [7:0] ew;
        logic [2:0] ecr;
        logic       erun;
        logic       edone;
        logic [7:0] erd;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] instr;
    logic       instr_valid;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       cnt_en;
    logic [7:0] addr_out;
    logic [7:0] wc_out;
    logic [2:0] cr_out;
    logic       run;
    logic       done;
`ifdef DMA_DONE_IRQ_EN
    logic       irq_clr;
    logic       irq;
`endif

    int checks;
    int failures;
    vec_t tv[$];
    logic [7:0] sb[$];

    am2940_dma_channel #(.W(8), .CR_RESET(3'b000)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
`ifdef DMA_DONE_IRQ_EN
        .irq_clr     (irq_clr),
        .irq         (irq),
`endif
        .cnt_en      (cnt_en),
        .addr_out    (addr_out),
        .wc_out      (wc_out),
        .cr_out      (cr_out),
        .run         (run),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic iv,
                                input logic [2:0] op, input logic [7:0] din,
                                input logic ce, input logic [7:0] ea,
                                input logic [7:0] ew, input logic [2:0] ecr,
                                input logic erun, input logic edone,
                                input logic [7:0] erd);
        vec_t v;
        v.r = r; v.iv = iv; v.op = op; v.din = din; v.ce = ce;
        v.ea = ea; v.ew = ew; v.ecr = ecr; v.erun = erun;
        v.edone = edone; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic pend;
        logic [7:0] e;
        @(negedge clk);
        rst         = v.r;
        instr_valid = v.iv;
        instr       = v.op;
        data_in     = v.din;
        cnt_en      = v.ce;
        pend = v.iv && !v.r &&
               (v.op == RDCR || v.op == RDWC || v.op == RDAC);
        if (pend) sb.push_back(v.erd);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d addr", idx), 32'(addr_out), 32'(v.ea));
        chk($sformatf("v%0d wc", idx), 32'(wc_out), 32'(v.ew));
        chk($sformatf("v%0d cr", idx), 32'(cr_out), 32'(v.ecr));
        chk($sformatf("v%0d run", idx), 32'(run), 32'(v.erun));
        chk($sformatf("v%0d done", idx), 32'(done), 32'(v.edone));
        chk($sformatf("v%0d data_oe", idx), 32'(data_oe), 32'(pend));
        if (data_oe === 1'b1) begin
            if (sb.size() == 0) begin
                chk($sformatf("v%0d sb_empty", idx), 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d data_out", idx), 32'(data_out), 32'(e));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 3'b000;
        data_in = 8'h00;
        cnt_en = 1'b0;
`ifdef DMA_DONE_IRQ_EN
        irq_clr = 1'b0;
`endif

        // reset
        tv.push_back(mk(1,0,WRCR,8'h00,0, 8'h00,8'h00,3'd0,0,1,0));
        tv.push_back(mk(1,0,WRCR,8'h00,0, 8'h00,8'h00,3'd0,0,1,0));
        // mode 0 increment
        tv.push_back(mk(0,1,LDAD,8'h10,0, 8'h10,8'h00,3'd0,0,1,0));
        tv.push_back(mk(0,1,LDWC,8'h03,0, 8'h10,8'h03,3'd0,0,0,0));
        tv.push_back(mk(0,1,ENCT,8'h00,1, 8'h10,8'h03,3'd0,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h11,8'h02,3'd0,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h12,8'h01,3'd0,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h13,8'h00,3'd0,1,1,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h13,8'h00,3'd0,1,1,0));
        tv.push_back(mk(0,1,RDAC,8'h00,0, 8'h13,8'h00,3'd0,1,1,8'h13));
        tv.push_back(mk(0,1,RDWC,8'h00,0, 8'h13,8'h00,3'd0,1,1,8'h00));
        // mode 1 decrement
        tv.push_back(mk(0,1,WRCR,8'h05,0, 8'h13,8'h00,3'd5,0,0,0));
        tv.push_back(mk(0,1,LDAD,8'h05,0, 8'h05,8'h00,3'd5,0,0,0));
        tv.push_back(mk(0,1,LDWC,8'h04,0, 8'h05,8'h00,3'd5,0,0,0));
        tv.push_back(mk(0,1,ENCT,8'h00,0, 8'h05,8'h00,3'd5,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h04,8'h01,3'd5,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h03,8'h02,3'd5,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h02,8'h03,3'd5,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h01,8'h04,3'd5,1,1,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h01,8'h04,3'd5,1,1,0));
        tv.push_back(mk(0,1,RDCR,8'h00,0, 8'h01,8'h04,3'd5,1,1,8'h05));
        tv.push_back(mk(0,1,REIN,8'h00,0, 8'h05,8'h00,3'd5,0,0,0));
        // mode 2 address compare with wrap
        tv.push_back(mk(0,1,WRCR,8'h02,0, 8'h05,8'h00,3'd2,0,0,0));
        tv.push_back(mk(0,1,LDAD,8'hFE,0, 8'hFE,8'h00,3'd2,0,0,0));
        tv.push_back(mk(0,1,LDWC,8'h01,0, 8'hFE,8'h01,3'd2,0,0,0));
        tv.push_back(mk(0,1,ENCT,8'h00,1, 8'hFE,8'h01,3'd2,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'hFF,8'h01,3'd2,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h00,8'h01,3'd2,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h01,8'h01,3'd2,1,1,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h01,8'h01,3'd2,1,1,0));
        tv.push_back(mk(0,1,RDAC,8'h00,0, 8'h01,8'h01,3'd2,1,1,8'h01));
        // mode 3 free-running wrap
        tv.push_back(mk(0,1,WRCR,8'h00,0, 8'h01,8'h01,3'd0,0,0,0));
        tv.push_back(mk(0,1,LDWC,8'hFE,0, 8'h01,8'hFE,3'd0,0,0,0));
        tv.push_back(mk(0,1,WRCR,8'h03,0, 8'h01,8'hFE,3'd3,0,0,0));
        tv.push_back(mk(0,1,ENCT,8'h00,0, 8'h01,8'hFE,3'd3,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h02,8'hFF,3'd3,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h03,8'h00,3'd3,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h04,8'h01,3'd3,1,0,0));
        tv.push_back(mk(0,1,LDAD,8'h40,1, 8'h40,8'h01,3'd3,0,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h40,8'h01,3'd3,0,0,0));
        // mode 0 with WC=0: zero transfers
        tv.push_back(mk(0,1,WRCR,8'h00,0, 8'h40,8'h01,3'd0,0,0,0));
        tv.push_back(mk(0,1,LDWC,8'h00,0, 8'h40,8'h00,3'd0,0,1,0));
        tv.push_back(mk(0,1,ENCT,8'h00,1, 8'h40,8'h00,3'd0,1,1,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h40,8'h00,3'd0,1,1,0));
        // mode 1 with WR=0: zero transfers
        tv.push_back(mk(0,1,WRCR,8'h01,0, 8'h40,8'h00,3'd1,0,1,0));
        tv.push_back(mk(0,1,ENCT,8'h00,1, 8'h40,8'h00,3'd1,1,1,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'h40,8'h00,3'd1,1,1,0));
        // decrement wrap below zero
        tv.push_back(mk(0,1,WRCR,8'h04,0, 8'h40,8'h00,3'd4,0,1,0));
        tv.push_back(mk(0,1,LDAD,8'h00,0, 8'h00,8'h00,3'd4,0,1,0));
        tv.push_back(mk(0,1,LDWC,8'h02,0, 8'h00,8'h02,3'd4,0,0,0));
        tv.push_back(mk(0,1,ENCT,8'h00,1, 8'h00,8'h02,3'd4,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'hFF,8'h01,3'd4,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'hFE,8'h00,3'd4,1,1,0));
        // reset mid-count drops the pending read
        tv.push_back(mk(0,1,WRCR,8'h00,0, 8'hFE,8'h00,3'd0,0,1,0));
        tv.push_back(mk(0,1,LDWC,8'h05,0, 8'hFE,8'h05,3'd0,0,0,0));
        tv.push_back(mk(0,1,ENCT,8'h00,1, 8'hFE,8'h05,3'd0,1,0,0));
        tv.push_back(mk(0,0,WRCR,8'h00,1, 8'hFF,8'h04,3'd0,1,0,0));
        tv.push_back(mk(1,1,RDAC,8'h00,1, 8'h00,8'h00,3'd0,0,1,0));
        tv.push_back(mk(0,0,WRCR,8'h00,0, 8'h00,8'h00,3'd0,0,1,0));

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i], i);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

`ifdef DMA_DONE_IRQ_EN
        apply(mk(1,0,WRCR,8'h00,0, 8'h00,8'h00,3'd0,0,1,0), 100);
        chk("irq_reset", 32'(irq), 32'd0);
        apply(mk(0,1,LDWC,8'h02,0, 8'h00,8'h02,3'd0,0,0,0), 101);
        apply(mk(0,1,ENCT,8'h00,1, 8'h00,8'h02,3'd0,1,0,0), 102);
        apply(mk(0,0,WRCR,8'h00,1, 8'h01,8'h01,3'd0,1,0,0), 103);
        apply(mk(0,0,WRCR,8'h00,1, 8'h02,8'h00,3'd0,1,1,0), 104);
        chk("irq_same_cycle", 32'(irq), 32'd0);
        apply(mk(0,0,WRCR,8'h00,0, 8'h02,8'h00,3'd0,1,1,0), 105);
        chk("irq_set", 32'(irq), 32'd1);
        apply(mk(0,0,WRCR,8'h00,0, 8'h02,8'h00,3'd0,1,1,0), 106);
        chk("irq_sticky", 32'(irq), 32'd1);
        irq_clr = 1'b1;
        apply(mk(0,0,WRCR,8'h00,0, 8'h02,8'h00,3'd0,1,1,0), 107);
        irq_clr = 1'b0;
        chk("irq_clr", 32'(irq), 32'd0);
        apply(mk(0,1,LDWC,8'h03,0, 8'h02,8'h03,3'd0,0,0,0), 108);
        apply(mk(0,1,ENCT,8'h00,1, 8'h02,8'h03,3'd0,1,0,0), 109);
        apply(mk(0,0,WRCR,8'h00,1, 8'h03,8'h02,3'd0,1,0,0), 110);
        apply(mk(1,0,WRCR,8'h00,1, 8'h00,8'h00,3'd0,0,1,0), 111);
        chk("irq_rst_mid", 32'(irq), 32'd0);
        apply(mk(0,0,WRCR,8'h00,0, 8'h00,8'h00,3'd0,0,1,0), 112);
        chk("irq_after_rst", 32'(irq), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
